// File: rtl/plane_pkg.sv
// plane_pkg: shared widths, the timing-state enum and the dx*HPIX span helper
// for the perspective floor-plane scanner (plane_scanner, plane_scroll).
package plane_pkg;

  localparam int ACC_W    = 17;  // U/V accumulator width, wraps mod 2^17
  localparam int TEX_FRAC = 10;  // fractional bits: 1 texel = 1024
  localparam int DX_W     = 11;  // per-pixel step from plane_dx_rom
  localparam int ROW_W    = 8;   // row index into plane_dx_rom
  localparam int HPIX     = 320; // half the active line width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } plane_state_t;

  // dx*HPIX built from two shifts (256 + 64) so no multiplier is inferred.
  // The result wraps to ACC_W bits like every other accumulator quantity.
  function automatic logic [ACC_W-1:0] dx_span(input logic [DX_W-1:0] step);
    logic [ACC_W-1:0] ext;
    ext = {{(ACC_W-DX_W){1'b0}}, step};
    return (ext << 8) + (ext << 6);
  endfunction

endpackage

// File: rtl/plane_scroll.sv
// plane_scroll: per-frame U/V scroll counter pair for the floor plane.
// Configuration macro: PLANE_SCROLL_EN. When defined, each frame_start pulse
// adds SPEED_U / SPEED_V to the 17-bit wrapping scroll registers. When
// undefined, both outputs are constant 0 and frame_start is ignored.
// Ports:
//   clk         in   pixel clock
//   rst         in   asynchronous active-high reset
//   frame_start in   one-cycle pulse per frame
//   scroll_u    out  17-bit U scroll offset
//   scroll_v    out  17-bit V scroll offset
module plane_scroll
  import plane_pkg::*;
#(
  parameter logic [ACC_W-1:0] SPEED_U = 17'd96,
  parameter logic [ACC_W-1:0] SPEED_V = 17'd512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  output logic [ACC_W-1:0] scroll_u,
  output logic [ACC_W-1:0] scroll_v
);

`ifdef PLANE_SCROLL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_u <= '0;
      scroll_v <= '0;
    end else if (frame_start) begin
      scroll_u <= scroll_u + SPEED_U;
      scroll_v <= scroll_v + SPEED_V;
    end
  end
`else
  // Static floor: the inputs and speeds are intentionally left without a sink.
  logic unused_cfg;
  assign unused_cfg = ^{clk, rst, frame_start, SPEED_U, SPEED_V};
  assign scroll_u   = '0;
  assign scroll_v   = '0;
`endif

endmodule

// File: rtl/plane_scanner.sv
// plane_scanner: per-pixel texture-coordinate generator for the perspective
// floor plane. At each floor line_start it latches the row index for
// plane_dx_rom, loads U/V starting points from the returned step one cycle
// later, then walks U by dx per active pixel and emits texel addresses to
// charrom one cycle after each pix_en.
// Configuration macro: PLANE_SCROLL_EN (per-frame scrolling, see plane_scroll).
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous active-high reset
//   frame_start  in   one-cycle pulse per frame
//   line_start   in   one-cycle pulse, >=3 cycles before first pix_en
//   vpos[9:0]    in   current scanline, valid with line_start
//   pix_en       in   active-video pixel strobe
//   dx_row[7:0]  out  row index to plane_dx_rom
//   dx[10:0]     in   per-pixel step from plane_dx_rom (combinational)
//   char         out  checkerboard character select
//   xaddr[4:0]   out  texel column
//   yaddr[4:0]   out  texel row
//   out_valid    out  outputs carry a floor pixel
module plane_scanner
  import plane_pkg::*;
#(
  parameter int                HORIZON = 240,
  parameter logic [ACC_W-1:0]  SPEED_U = 17'd96,
  parameter logic [ACC_W-1:0]  SPEED_V = 17'd512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [9:0]       vpos,
  input  logic             pix_en,
  output logic [ROW_W-1:0] dx_row,
  input  logic [DX_W-1:0]  dx,
  output logic             char,
  output logic [4:0]       xaddr,
  output logic [4:0]       yaddr,
  output logic             out_valid
);

  logic [ACC_W-1:0] scroll_u;
  logic [ACC_W-1:0] scroll_v;
  logic [ACC_W-1:0] u;
  logic [ACC_W-1:0] v_line;
  logic [ACC_W-1:0] dx_ext;
  logic             floor_line;
  logic             is_floor;
  logic             load_en;
  logic             pix_go;
  plane_state_t     state_q;
  plane_state_t     state_d;

  plane_scroll #(
    .SPEED_U (SPEED_U),
    .SPEED_V (SPEED_V)
  ) u_scroll (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .scroll_u    (scroll_u),
    .scroll_v    (scroll_v)
  );

  assign is_floor = (vpos >= 10'(HORIZON)) && (vpos < 10'd480);
  assign dx_ext   = {{(ACC_W-DX_W){1'b0}}, dx};

  // Only bits [15:10] of v_line address the texture.
  logic unused_v;
  assign unused_v = ^{v_line[ACC_W-1], v_line[TEX_FRAC-1:0]};

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    pix_go  = 1'b0;
    // line_start always wins, including over a pixel in the same cycle.
    if (line_start) begin
      state_d = is_floor ? LOAD : IDLE;
    end else begin
      case (state_q)
        LOAD:    state_d = RUN;
        default: state_d = state_q;
      endcase
    end
    // dx is valid one cycle after line_start, once dx_row has settled.
    if (state_q == LOAD) load_en = floor_line;
    if (state_q == RUN)  pix_go  = pix_en && floor_line && !line_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      floor_line <= 1'b0;
      dx_row     <= '0;
      u          <= '0;
      v_line     <= '0;
      out_valid  <= 1'b0;
      xaddr      <= '0;
      yaddr      <= '0;
      char       <= 1'b0;
    end else begin
      state_q <= state_d;

      // line start: latch floor flag and ROM row
      if (line_start) begin
        floor_line <= is_floor;
        if (is_floor) dx_row <= ROW_W'(vpos - 10'(HORIZON));
      end

      // load: centre the line so pixel 320 lands on scroll_u
      if (load_en) begin
        u      <= scroll_u - dx_span(dx);
        v_line <= scroll_v + (dx_ext << 4);
      end else if (pix_go) begin
        u <= u + dx_ext;
      end

      // pixel output: addresses from the pre-increment U
      out_valid <= pix_go;
      if (pix_go) begin
        xaddr <= u[TEX_FRAC+4:TEX_FRAC];
        yaddr <= v_line[TEX_FRAC+4:TEX_FRAC];
        char  <= u[TEX_FRAC+5] ^ v_line[TEX_FRAC+5];
      end
    end
  end

endmodule

// File: tb/tb_plane_scanner.sv
module tb_plane_scanner;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        line_start;
  logic [9:0]  vpos;
  logic        pix_en;
  logic [7:0]  dx_row;
  logic [10:0] dx;
  logic        char;
  logic [4:0]  xaddr;
  logic [4:0]  yaddr;
  logic        out_valid;

  int checks;
  int errors;

  logic [4:0] px [640];
  logic [4:0] py [640];
  logic       pc [640];
  int         nvalid;
  int         nhigh;

  plane_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .line_start  (line_start),
    .vpos        (vpos),
    .pix_en      (pix_en),
    .dx_row      (dx_row),
    .dx          (dx),
    .char        (char),
    .xaddr       (xaddr),
    .yaddr       (yaddr),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM stand-in: row 10 returns 0x100, other rows 0x40 + row.
  always_comb begin
    dx = (dx_row == 8'd10) ? 11'h100 : (11'h040 + {3'b000, dx_row});
  end

`ifdef PLANE_SCROLL_EN
  localparam int Y11 = 9;   // v = 4096 + 11*512
  localparam int X11 = 17;  // u0 = 49152 + 11*96
  localparam int Y12 = 10;  // v = 4096 + 12*512
  localparam int X12 = 17;  // u0 = 49152 + 12*96
`else
  localparam int Y11 = 4;
  localparam int X11 = 16;
  localparam int Y12 = 4;
  localparam int X12 = 16;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line start (optionally with frame_start), 2 idle cycles, then npix pixels;
  // records every valid output in px/py/pc.
  task automatic run_line(input logic [9:0] vp, input int npix, input bit with_frame);
    line_start  = 1'b1;
    frame_start = with_frame;
    vpos        = vp;
    @(negedge clk);
    line_start  = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    nvalid = 0;
    for (int k = 0; k <= npix; k++) begin
      pix_en = (k < npix);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (nvalid < 640) begin
          px[nvalid] = xaddr;
          py[nvalid] = yaddr;
          pc[nvalid] = char;
        end
        nvalid++;
      end
    end
    pix_en = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    vpos        = '0;
    pix_en      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_dx_row", dx_row, 0);
    check("rst_valid", out_valid, 0);
    check("rst_xaddr", xaddr, 0);
    check("rst_yaddr", yaddr, 0);
    check("rst_char", char, 0);

    // Static floor row 10, dx=0x100: u0=0xC000, v=0x1000
    run_line(10'd250, 640, 1'b0);
    check("f250_dx_row", dx_row, 10);
    check("f250_count", nvalid, 640);
    check("f250_p0_x", px[0], 16);
    check("f250_p0_y", py[0], 4);
    check("f250_p0_c", pc[0], 1);
    check("f250_p4_x", px[4], 17);
    check("f250_p319_x", px[319], 31);
    check("f250_p319_c", pc[319], 1);
    check("f250_p320_x", px[320], 0);
    check("f250_p320_c", pc[320], 0);

    // Non-floor lines: no output, dx_row held
    run_line(10'd100, 640, 1'b0);
    check("nf100_count", nvalid, 0);
    check("nf100_dx_row", dx_row, 10);
    run_line(10'd480, 640, 1'b0);
    check("nf480_count", nvalid, 0);
    check("nf480_dx_row", dx_row, 10);

    // Last floor row: dx=303, u0=34112, v=4848
    run_line(10'd479, 4, 1'b0);
    check("f479_dx_row", dx_row, 239);
    check("f479_p0_x", px[0], 1);
    check("f479_p0_y", py[0], 4);
    check("f479_p0_c", pc[0], 1);

    // Horizon row: dx=64, u0=110592, v=1024
    run_line(10'd240, 4, 1'b0);
    check("f240_dx_row", dx_row, 0);
    check("f240_p0_x", px[0], 12);
    check("f240_p0_y", py[0], 1);
    check("f240_p0_c", pc[0], 1);

    // line_start while pix_en is high mid-line
    line_start = 1'b1;
    vpos       = 10'd250;
    @(negedge clk);
    line_start = 1'b0;
    repeat (2) @(negedge clk);
    pix_en = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_run_x", xaddr, 28);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    check("ls_pix_valid_t", out_valid, 0);
    @(negedge clk);
    check("ls_pix_valid_t1", out_valid, 0);
    @(negedge clk);
    check("ls_pix_valid_t2", out_valid, 1);
    check("ls_pix_x_u0", xaddr, 16);
    check("ls_pix_y", yaddr, 4);
    check("ls_pix_c", char, 1);

    // Async reset mid-line with pix_en still high
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_xaddr", xaddr, 0);
    check("arst_yaddr", yaddr, 0);
    check("arst_char", char, 0);
    check("arst_dx_row", dx_row, 0);
    @(negedge clk);
    rst   = 1'b0;
    nhigh = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nhigh++;
    end
    check("arst_no_valid", nhigh, 0);
    line_start = 1'b1;
    vpos       = 10'd250;
    @(negedge clk);
    line_start = 1'b0;
    check("arst_ls_t", out_valid, 0);
    @(negedge clk);
    check("arst_ls_t1", out_valid, 0);
    @(negedge clk);
    check("arst_ls_t2", out_valid, 1);
    check("arst_ls_x", xaddr, 16);
    pix_en = 1'b0;
    @(negedge clk);

    // 11 frames of scroll, then the same floor row
    for (int f = 0; f < 11; f++) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
    end
    run_line(10'd250, 4, 1'b0);
    check("scr11_count", nvalid, 4);
    check("scr11_p0_y", py[0], Y11);
    check("scr11_p0_x", px[0], X11);
    check("scr11_p0_c", pc[0], 1);

    // frame_start coincident with line_start: load sees frame 12
    run_line(10'd250, 4, 1'b1);
    check("scr12_p0_y", py[0], Y12);
    check("scr12_p0_x", px[0], X12);
    check("scr12_p0_c", pc[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plane_scanner.md
# plane_scanner

Per-pixel texture-coordinate generator for the perspective floor plane. On each floor scanline it presents a row index to `plane_dx_rom`, takes the returned 11-bit per-pixel step, and walks a fixed-point U/V accumulator across the line. It emits `char`/`xaddr`/`yaddr` to `charrom` one cycle after each active pixel. It sits between the VGA timing generator, which is upstream, and `charrom`→`palette`, which are downstream.

## Interface
Parameters:
- `HORIZON`, 240: first floor scanline (vpos); floor rows are `HORIZON..479`.
- `SPEED_U`, 17'd96: U scroll added per frame (1 texel = 1024).
- `SPEED_V`, 17'd512: V scroll added per frame.

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse, once per frame, before the first line
- `line_start`  in  1  one-cycle pulse, ≥3 cycles before the line's first `pix_en`
- `vpos`  in  10  current scanline, valid at `line_start`
- `pix_en`  in  1  active-video pixel strobe (640/line)
- `dx_row`  out  8  row index to `plane_dx_rom`
- `dx`  in  11  step from `plane_dx_rom` (combinational on `dx_row`)
- `char`  out  1  character select to `charrom`
- `xaddr`  out  5  texel column
- `yaddr`  out  5  texel row
- `out_valid`  out  1  outputs carry a floor pixel

## Operation
- **Accumulators.** All accumulators are 17-bit unsigned and wrap mod 2^17: `scroll_u`, `scroll_v`, `u`, `v_line`.
- **Per frame.** `frame_start` applies `scroll_u += SPEED_U` and `scroll_v += SPEED_V`.
- **Line start (cycle T).** `line_start` with `HORIZON ≤ vpos < 480`:
  - `dx_row <= vpos - HORIZON`.
  - `floor_line <= 1`.
  - Otherwise `floor_line <= 0` and `dx_row` holds.
- **Cycle T+1.** If `floor_line`:
  - `u <= scroll_u - dx*320`. Computed as `(dx<<8)+(dx<<6)`; no multiplier.
  - `v_line <= scroll_v + (dx<<4)`.
- **Per pixel.** Each cycle with `pix_en && floor_line`:
  - `xaddr <= u[14:10]`, `yaddr <= v_line[14:10]`, `char <= u[15]^v_line[15]`, `out_valid <= 1`.
  - `u <= u + dx`.
- **Otherwise.** `out_valid <= 0`; `xaddr`/`yaddr`/`char` hold their last values.
- **Boundary rules:**
  - `line_start` with `pix_en` in the same cycle: the reload wins and no pixel is output.
  - `frame_start` with `line_start` in the same cycle: T+1 uses the already-updated scroll values.
  - `pix_en` on a non-floor line: ignored.
  - `vpos ≥ 480`: treated as non-floor.
  - U wraps silently, giving a seamless tiling checkerboard.

## Timing
- **Reset values.** All outputs and state are 0: `dx_row=0`, `out_valid=0`, `char/xaddr/yaddr=0`, `floor_line=0`, scrolls 0.
- **Async reset.** `rst` mid-line clears immediately. The next valid output requires a fresh `line_start`.
- **Latency.**
  - `line_start` → `dx_row` valid: 1 cycle.
  - `u` loaded: 2 cycles.
  - `pix_en` → `out_valid`/addresses: 1 cycle, registered.
  - Throughput: 1 pixel/cycle.
- **Pixel k.** Output for pixel k uses `u0 + k*dx`.
- **Timing state machine.** `IDLE` → (`line_start`, floor) `LOAD` → `RUN` → (`line_start`) `LOAD` | (`line_start`, non-floor) `IDLE`. `rst` forces `IDLE`.

## Configuration
- **`PLANE_SCROLL_EN` defined:** scroll registers advance per frame as above.
- **`PLANE_SCROLL_EN` undefined:**
  - `scroll_u`/`scroll_v` are constant 0 and the scroll logic is removed.
  - `frame_start` has no effect.
  - The floor is static.

## Structure
- Package `plane_pkg`:
  - `ACC_W=17`, `TEX_FRAC=10`, `DX_W=11`, `ROW_W=8`, `HPIX=320`.
  - State enum `plane_state_t {IDLE, LOAD, RUN}`.
- Sub-module `plane_scroll`:
  - Frame scroll counter pair.
  - Wrapped entirely in `PLANE_SCROLL_EN`; constant outputs when disabled.

## Test plan
- **Reset.** `rst` asserted mid-line with `pix_en` high → all outputs 0 on the same edge. `out_valid` stays 0 until `line_start` plus 2 cycles.
- **Non-floor line.** `line_start` at `vpos=100`, then 640 `pix_en` → `out_valid` never asserts and `dx_row` is unchanged.
- **Floor row, static.** Scroll disabled or frame 0, `vpos=250` → `dx_row=10`. With the bench returning `dx=0x100`:
  - Pixel 0: `xaddr=16`, `yaddr=4`, `char=1`.
  - Pixel 4: `xaddr=17`.
  - Pixel 320: `xaddr=0`, `char=0`.
- **Scroll.** `PLANE_SCROLL_EN`, 11 `frame_start` pulses, then the floor row above → `scroll_v=5632`. `v_line=0x1000+5632=9728` → `yaddr=9`.
- **Simultaneous frame and line start.** `frame_start` and `line_start` in the same cycle → the T+1 load reflects the incremented scroll (compare against the previous case shifted by one frame).
- **Line start during `pix_en`.** `line_start` while `pix_en` is high → `out_valid=0` the next cycle; `u` reloads to `u0` regardless of the prior position.
